// File: rtl/axil_arbiter_wr.sv
// Write-channel arbiter: grants the shared AXI-Lite slave write port to one master
// for a whole AW/W/B transaction, with round-robin or fixed priority and a watchdog.
//
// state | meaning
// IDLE  | no grant held; picks the next master when any request is up
// DATA  | grant held; waiting for both the AW and the W handshake
// RESP  | grant held; waiting for the B handshake
module axil_arbiter_wr #(
  parameter int NUMBER_MASTER  = 4,
  parameter int ARBITER_WR     = 1,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDW = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] request_wr,
  output logic [NUMBER_MASTER-1:0] grant_wr,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic [NUMBER_MASTER-1:0] m_axil_awvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_wvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_bready,
  input  logic                     s_axil_awready,
  input  logic                     s_axil_wready,
  input  logic                     s_axil_bvalid
);

  localparam int CW_RAW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW         = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int WD_LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] WD_LIMIT = WD_LIMIT_I[CW-1:0];

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  last_ptr;
  logic            aw_done;
  logic            w_done;
  logic [CW-1:0]   wd_cnt;

  logic            hi_found;
  logic            lo_found;
  logic [IDW-1:0]  hi_idx;
  logic [IDW-1:0]  lo_idx;
  logic [IDW-1:0]  next_id;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic            wd_fire;
  logic            abort;
  logic            done;

  // Lowest requester overall, and lowest requester strictly above the last grant.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      if (request_wr[i]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDW'(i);
        end
        if (!hi_found && (i > int'(last_ptr))) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    next_id = ((ARBITER_WR != 0) && hi_found) ? hi_idx : lo_idx;
  end

  always_comb begin
    aw_hs   = m_axil_awvalid[grant_id] & s_axil_awready;
    w_hs    = m_axil_wvalid[grant_id] & s_axil_wready;
    b_hs    = s_axil_bvalid & m_axil_bready[grant_id];
    wd_fire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LIMIT);
    done    = (state == RESP) && b_hs;
    // A completing B beats the watchdog on the same cycle.
    abort   = ((state == DATA) || (state == RESP)) && wd_fire && !done;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      grant_wr    <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last_ptr    <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (|request_wr) begin
          state    <= DATA;
          grant_wr <= NUMBER_MASTER'(1) << next_id;
          grant_id <= next_id;
          last_ptr <= next_id;
          busy     <= 1'b1;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          wd_cnt   <= '0;
        end
      end else if (abort || done) begin
        state       <= IDLE;
        grant_wr    <= '0;
        grant_id    <= '0;
        busy        <= 1'b0;
        timeout_err <= abort;
      end else begin
        if (wd_cnt != {CW{1'b1}}) begin
          wd_cnt <= wd_cnt + CW'(1);
        end
        if (state == DATA) begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state <= RESP;
          end
        end
      end
    end
  end

endmodule
